fifo_uart_drain: RTL and testbench
==================================

Name: fifo_uart_drain

Overview:
Read side of the capture path: drains bytes from fifo_stack and serialises them on a UART TX line (8N1, LSB first) to the ICEstick FTDI bridge. The block pops one byte at a time using the FIFO's empty/busy/pop handshake. It frames each byte, then fetches the next byte once the stop bit has been sent. It sits between fifo_stack and the board's TX pin; the USB3300 parser fills the FIFO on the write side.

Parameters:
CLK_FREQ, 12000000, system clock frequency in Hz.
BAUD, 115200, line rate in bit/s.
DIVIDER, CLK_FREQ/BAUD (104), clocks per UART bit. Must be >= 2; the bench overrides it to 4.

Ports:
clk  in  1  system clock; all logic runs on the rising edge.
reset  in  1  synchronous, active-high reset.
enable  in  1  when high, new bytes may be fetched; a frame already in progress always completes.
FIFO_DATA  in  8  head byte presented by fifo_stack (its O_DATA output).
fifo_empty  in  1  FIFO holds no data.
fifo_busy  in  1  FIFO is processing a save or pop; head data is not yet stable.
pop  out  1  one-cycle request that removes the head byte (drives fifo_stack pop).
tx  out  1  UART line; idles high.
tx_busy  out  1  high from fetch until the end of the stop bit.

Behaviour:
- Reset values: tx=1, pop=0, tx_busy=0, state=IDLE, baud counter=0, bit index=0, shift register=0. Reset asserted mid-frame aborts the frame; tx returns high on the next cycle.
- States: IDLE, FETCH, WAIT_FIFO, START, DATA, STOP.
- IDLE: when enable && !fifo_empty && !fifo_busy, latch FIFO_DATA into the shift register, assert pop for exactly one cycle, set tx_busy, go to FETCH. Otherwise remain in IDLE with tx=1.
- FETCH: guard cycle with pop=0, so fifo_busy has time to rise. Go to WAIT_FIFO.
- WAIT_FIFO: stay while fifo_busy=1. On the first cycle with fifo_busy=0, go to START and clear the baud counter.
- START: tx=0 for DIVIDER cycles, then go to DATA with bit index 0.
- DATA: tx=shift[0] for DIVIDER cycles, then shift right and increment the bit index. After bit 7, go to STOP.
- STOP: tx=1 for DIVIDER cycles, then clear tx_busy and go to IDLE.
- Baud counter: counts 0..DIVIDER-1 and wraps to 0 on each bit boundary. Width is clog2(DIVIDER).
- Bit timing: a frame is exactly 10*DIVIDER cycles from the first low cycle of the start bit to the last cycle of the stop bit.
- Back-to-back: minimum gap between the end of one stop bit and the next start bit is 3 cycles (IDLE, FETCH, WAIT_FIFO with busy already low). No extra idle time is inserted.
- Empty/busy boundary: pop is never asserted while fifo_empty=1 or fifo_busy=1. The FIFO going empty mid-frame has no effect on the current frame.
- enable dropped mid-frame: the current frame completes and the block then holds in IDLE. Dropping enable in the same cycle a pop would fire suppresses that pop.
- Data is sampled only in the IDLE pop cycle. Later changes on FIFO_DATA do not affect the frame in flight.

Decomposition:
- Shared package/include: UART frame constants (START_BIT=0, STOP_BIT=1, DATA_BITS=8) and state encodings (3-bit localparams).
- Natural sub-module: uart_tx_core. It takes start/data in and gives tx/done out, and owns the baud counter and shift register.
- fifo_uart_drain keeps the FIFO handshake FSM and instantiates uart_tx_core.

Test Plan:
1. Reset with fifo_empty=1, DIVIDER=4 -> tx=1, pop=0, tx_busy=0 for 50 cycles.
2. FIFO holds 0x41 ("A"), enable=1 -> one pop pulse, then tx is 0 for 4 cycles and carries bits 1,0,0,0,0,0,1,0 at 4 cycles each. Stop bit is high for 4 cycles; tx_busy then falls; frame length is 40 cycles.
3. FIFO holds 0x41, 0x5B, 0x63 -> three frames in that order, each start bit 3 cycles after the previous stop bit, and exactly 3 pop pulses in total.
4. fifo_busy held high 6 cycles after pop -> start bit is delayed until the first cycle after busy falls; no second pop occurs.
5. enable=0 with FIFO non-empty -> no pop and tx stays high. Clearing enable mid-frame of 0x63 -> the frame completes and no further pop follows.
6. reset pulsed during bit 3 of 0x5B -> tx=1 and tx_busy=0 on the next cycle. After reset releases, the block resumes with a fresh pop of the next head byte.

Source files
------------

// File: rtl/fifo_uart_drain_pkg.sv
// Shared UART frame constants and drain FSM state encodings.
package fifo_uart_drain_pkg;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int   DATA_BITS = 8;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_FETCH     = 3'd1;
  localparam logic [2:0] ST_WAIT_FIFO = 3'd2;
  localparam logic [2:0] ST_START     = 3'd3;
  localparam logic [2:0] ST_DATA      = 3'd4;
  localparam logic [2:0] ST_STOP      = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE,
    S_FETCH     = ST_FETCH,
    S_WAIT_FIFO = ST_WAIT_FIFO,
    S_START     = ST_START,
    S_DATA      = ST_DATA,
    S_STOP      = ST_STOP
  } state_e;

  function automatic logic is_framing(input state_e s);
    return (s == S_START) || (s == S_DATA) || (s == S_STOP);
  endfunction

endpackage

// File: rtl/fifo_uart_drain_uart_tx_core.sv
// 8N1 bit engine: baud counter, bit index and shift register, driven by the
// drain FSM's current and next state so tx is registered yet aligned to state.
module fifo_uart_drain_uart_tx_core
  import fifo_uart_drain_pkg::*;
#(
  parameter int DIVIDER = 104
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_i,
  input  logic [7:0] data_i,
  input  state_e     state_i,
  input  state_e     state_nx_i,
  output logic       tx_o,
  output logic       bit_end_o,
  output logic       last_bit_o
);

  localparam int CW = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(DIVIDER - 1);

  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          framing_s, tick_s;

  always_comb begin
    framing_s = is_framing(state_i);
    tick_s    = framing_s && (baud_q == BAUD_LAST);

    if (framing_s && !tick_s) begin
      baud_d = baud_q + CW'(1);
    end else begin
      baud_d = '0;
    end

    if (tick_s && (state_i == S_START)) begin
      bit_d = 3'd0;
    end else if (tick_s && (state_i == S_DATA)) begin
      bit_d = bit_q + 3'd1;
    end else begin
      bit_d = bit_q;
    end

    if (load_i) begin
      shift_d = data_i;
    end else if (tick_s && (state_i == S_DATA)) begin
      shift_d = {1'b0, shift_q[7:1]};
    end else begin
      shift_d = shift_q;
    end

    // Line level follows the state being entered, so it changes with the state.
    case (state_nx_i)
      S_START: tx_d = START_BIT;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = STOP_BIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      tx_q    <= STOP_BIT;
    end else begin
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  assign tx_o       = tx_q;
  assign bit_end_o  = tick_s;
  assign last_bit_o = (bit_q == 3'(DATA_BITS - 1));

endmodule

// File: rtl/fifo_uart_drain.sv
// Drains fifo_stack one byte at a time via the empty/busy/pop handshake and
// sends each byte as an 8N1 UART frame.
module fifo_uart_drain
  import fifo_uart_drain_pkg::*;
#(
  parameter int CLK_FREQ = 12000000,
  parameter int BAUD     = 115200,
  parameter int DIVIDER  = CLK_FREQ / BAUD
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] FIFO_DATA,
  input  logic       fifo_empty,
  input  logic       fifo_busy,
  output logic       pop,
  output logic       tx,
  output logic       tx_busy
);

  state_e state_q, state_d;
  logic   tx_busy_q;
  logic   pop_s;
  logic   bit_end_s, last_bit_s;

  // Pop is combinational so it lands in the IDLE decision cycle; FETCH is the guard.
  always_comb begin
    pop_s   = 1'b0;
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (!reset && enable && !fifo_empty && !fifo_busy) begin
          pop_s   = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH:     state_d = S_WAIT_FIFO;
      S_WAIT_FIFO: state_d = fifo_busy ? S_WAIT_FIFO : S_START;
      S_START:     state_d = bit_end_s ? S_DATA : S_START;
      S_DATA:      state_d = (bit_end_s && last_bit_s) ? S_STOP : S_DATA;
      S_STOP:      state_d = bit_end_s ? S_IDLE : S_STOP;
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      tx_busy_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_busy_q <= (state_d != S_IDLE);
    end
  end

  fifo_uart_drain_uart_tx_core #(
    .DIVIDER(DIVIDER)
  ) u_tx_core (
    .clk        (clk),
    .reset      (reset),
    .load_i     (pop_s),
    .data_i     (FIFO_DATA),
    .state_i    (state_q),
    .state_nx_i (state_d),
    .tx_o       (tx),
    .bit_end_o  (bit_end_s),
    .last_bit_o (last_bit_s)
  );

  assign pop     = pop_s;
  assign tx_busy = tx_busy_q;

endmodule

// File: tb/tb_fifo_uart_drain.sv
// Bench for fifo_uart_drain: FIFO model plus a frame-timing reference model.
module tb_fifo_uart_drain;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset, enable, fifo_empty, fifo_busy;
  logic [7:0] FIFO_DATA;
  logic       pop, tx, tx_busy;

  always #5 clk = ~clk;

  fifo_uart_drain #(.DIVIDER(D)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .FIFO_DATA  (FIFO_DATA),
    .fifo_empty (fifo_empty),
    .fifo_busy  (fifo_busy),
    .pop        (pop),
    .tx         (tx),
    .tx_busy    (tx_busy)
  );

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  logic [7:0] fq[$];
  int   busy_cnt = 0;
  int   blen_mode = 1;
  bit   has_frame = 0;
  int   f_pop = 0;
  int   f_start = 0;
  logic [7:0] f_byte = 8'h00;
  int   act_pops = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  function automatic bit in_window();
    return has_frame && (cyc > f_pop) && (cyc <= f_start + 10*D - 1);
  endfunction

  function automatic logic exp_line();
    int k;
    if (has_frame && (cyc >= f_start) && (cyc < f_start + 10*D)) begin
      k = (cyc - f_start) / D;
      if (k == 0) return 1'b0;
      if (k == 9) return 1'b1;
      return f_byte[k-1];
    end
    return 1'b1;
  endfunction

  task automatic tick();
    bit exp_pop;
    int b;
    b = 0;
    fifo_empty = (fq.size() == 0);
    fifo_busy  = (busy_cnt > 0);
    FIFO_DATA  = (!fifo_empty && !fifo_busy) ? fq[0] : 8'($urandom);
    #2;
    exp_pop = !reset && enable && !fifo_empty && !fifo_busy && !in_window();
    check_eq("pop", {31'd0, pop}, {31'd0, exp_pop});
    check_eq("tx", {31'd0, tx}, {31'd0, exp_line()});
    check_eq("tx_busy", {31'd0, tx_busy}, {31'd0, in_window()});
    if (pop === 1'b1) act_pops++;
    if (exp_pop) begin
      f_byte    = fq.pop_front();
      has_frame = 1;
      f_pop     = cyc;
      b         = (blen_mode < 0) ? $urandom_range(0, 6) : blen_mode;
      f_start   = cyc + ((b + 2 > 3) ? b + 2 : 3);
    end
    if (reset) has_frame = 0;
    @(posedge clk);
    #1;
    cyc++;
    if (exp_pop) busy_cnt = b;
    else if (busy_cnt > 0) busy_cnt--;
  endtask

  task automatic run_idle(input int max);
    int n;
    n = 0;
    while ((fq.size() > 0 || busy_cnt > 0 || in_window()) && n < max) begin
      tick();
      n++;
    end
    if (n >= max) check_eq("idle_timeout", 32'd0, 32'd1);
    tick();
  endtask

  task automatic wait_data_bit(input int bit_no, input string tag);
    int n;
    n = 0;
    while (!(has_frame && cyc == f_start + (bit_no + 1)*D + 1) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) check_eq(tag, 32'd0, 32'd1);
  endtask

  initial begin
    int p0;
    reset = 1'b1; enable = 1'b0; fifo_empty = 1'b1; fifo_busy = 1'b0; FIFO_DATA = 8'h00;
    repeat (2) @(posedge clk);
    #1;

    // Reset and idle with an empty FIFO.
    repeat (10) tick();
    reset = 1'b0;
    repeat (40) tick();

    // Single 'A' frame.
    enable = 1'b1; blen_mode = 1;
    p0 = act_pops;
    fq.push_back(8'h41);
    run_idle(200);
    check_eq("pops_single", 32'(act_pops - p0), 32'd1);

    // Three back-to-back frames.
    blen_mode = 0;
    p0 = act_pops;
    fq = '{8'h41, 8'h5B, 8'h63};
    run_idle(400);
    check_eq("pops_three", 32'(act_pops - p0), 32'd3);

    // Long busy after pop delays the start bit.
    blen_mode = 6;
    p0 = act_pops;
    fq.push_back(8'h3C);
    run_idle(200);
    check_eq("pops_busy6", 32'(act_pops - p0), 32'd1);

    // Disabled with data waiting, then disable mid-frame.
    blen_mode = 1;
    enable = 1'b0;
    p0 = act_pops;
    fq = '{8'h63, 8'h7E};
    repeat (60) tick();
    check_eq("pops_disabled", 32'(act_pops - p0), 32'd0);
    enable = 1'b1;
    wait_data_bit(4, "wait_mid_frame");
    enable = 1'b0;
    p0 = act_pops;
    repeat (100) tick();
    check_eq("pops_after_disable", 32'(act_pops - p0), 32'd0);
    enable = 1'b1;
    run_idle(200);

    // Reset during bit 3, then a fresh pop of the next head byte.
    fq = '{8'h5B, 8'h22};
    wait_data_bit(3, "wait_bit3");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    p0 = act_pops;
    run_idle(300);
    check_eq("pops_after_reset", 32'(act_pops - p0), 32'd1);

    // Randomized traffic, busy lengths, enable toggles and reset pulses.
    blen_mode = -1;
    for (int i = 0; i < 3000; i++) begin
      if (fq.size() < 4 && $urandom_range(0, 7) == 0) fq.push_back(8'($urandom));
      if ($urandom_range(0, 49) == 0) enable = ~enable;
      reset = ($urandom_range(0, 399) == 0);
      tick();
    end
    reset = 1'b0;
    enable = 1'b1;
    run_idle(1000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
